// File: rtl/acc_requant_out_if.sv
// Output stream interface for acc_requant_out.
//   out_data   signed requantized result at the FIFO head
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts out_data when out_valid && out_ready
// The master modport is the producer (acc_requant_out). The slave modport is
// the consumer (output SRAM or next layer).
interface acc_requant_out_if #(
  parameter int OUT_WIDTH = 8
);
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/acc_requant_out.sv
// acc_requant_out: downstream stage of the global accumulator.
// Operation:
//   - start_acc opens a bit-serial accumulation window.
//   - When the window completes, the final accumulator value (nout_in) is captured.
//   - The captured value is requantized. This uses an arithmetic right shift,
//     round-half-up and signed saturation to OUT_WIDTH.
//   - Results are queued in a small FIFO that a valid/ready consumer drains.
// Optional feature: define REQUANT_RELU_EN to clamp negative results to 0
// before saturation.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_acc    opens a window. cfg_shift is sampled on the same edge.
//   nout_in      accumulator output. It is sampled only on the capture edge.
//   cfg_shift    right-shift amount
//   out_if       master side of the out_data/out_valid/out_ready stream
//   busy         window open or requant pending
//   fifo_count   entries held in the FIFO
//   ovf_err      sticky flag: a result was dropped on a full FIFO
//   clr_err      synchronous clear of ovf_err. Setting ovf_err wins over clearing it.
module acc_requant_out #(
  parameter int ACC_WIDTH   = 51,
  parameter int OUT_WIDTH   = 8,
  parameter int ACC_CYCLES  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_acc,
  input  logic signed [ACC_WIDTH-1:0]   nout_in,
  input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
  acc_requant_out_if.master             out_if,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf_err,
  input  logic                          clr_err
);

  localparam int          PTR_W  = $clog2(FIFO_DEPTH);
  localparam int          CNT_W  = $clog2(ACC_CYCLES + 2);
  localparam int          IW     = ACC_WIDTH + 1;
  localparam int unsigned MAX_SH = ACC_WIDTH - 1;
  localparam logic signed [IW-1:0] MAXV = {{(IW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COUNT, QUANT} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic signed [ACC_WIDTH-1:0]   raw;

  // nout_in lags the internal sum by one cycle. The capture therefore
  // happens one edge after cnt reaches ACC_CYCLES+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= '0;
      raw     <= '0;
    end else if (start_acc) begin
      state   <= COUNT;
      cnt     <= '0;
      shift_q <= cfg_shift;
    end else begin
      case (state)
        COUNT: begin
          if (cnt == CNT_W'(ACC_CYCLES + 1)) begin
            raw   <= nout_in;
            state <= QUANT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        QUANT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Requantization in ACC_WIDTH+1 bits so the rounding add cannot overflow.
  int unsigned                 sh;
  logic signed [IW-1:0]        ext, rnd, sum, v;
  logic [OUT_WIDTH-1:0]        q_val;

  always_comb begin
    sh  = (32'(shift_q) > MAX_SH) ? MAX_SH : 32'(shift_q);
    ext = {raw[ACC_WIDTH-1], raw};
    rnd = (sh == 0) ? '0 : (IW'(1) << (sh - 1));
    sum = ext + rnd;
    v   = sum >>> sh;
`ifdef REQUANT_RELU_EN
    if (v[IW-1]) v = '0;
`endif
    if (v > MAXV)      q_val = MAXV[OUT_WIDTH-1:0];
    else if (v < MINV) q_val = MINV[OUT_WIDTH-1:0];
    else               q_val = v[OUT_WIDTH-1:0];
  end

  // Output FIFO
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 push, pop, full, do_push, drop;

  always_comb begin
    push    = (state == QUANT);
    full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    pop     = out_if.out_ready && (count != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    do_push = push && (!full || pop);
    drop    = push && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= q_val;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop)         ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
    end
  end

  assign out_if.out_data  = mem[rd_ptr];
  assign out_if.out_valid = (count != '0);
  assign fifo_count       = count;

endmodule
